// File: rtl/core_ctrl_if.sv
// Control/handshake bundle between core_ctrl and the datapath/memory side.
// The master side is the controller; the slave side is the datapath and memory.
interface core_ctrl_if;
    logic        run_i;
    logic [31:0] ir_i;
    logic        mem_ready_i;
    logic [2:0]  alu_flag_i;
    logic        en_rf_o;
    logic        we_rf_o;
    logic        sel_rf_o;
    logic        en_pc_o;
    logic        load_pc_o;
    logic        we_ir_o;
    logic        load_addr_reg_o;
    logic        mar_src_o;
    logic        sel_alu_port_a_o;
    logic        sel_alu_port_b_o;
    logic [2:0]  alu_op_o;
    logic        re_mem_o;
    logic        we_mem_o;
    logic        halted_o;
    logic        illegal_o;
    logic        timeout_o;
    logic [2:0]  state_o;

    modport master (
        input  run_i, ir_i, mem_ready_i, alu_flag_i,
        output en_rf_o, we_rf_o, sel_rf_o, en_pc_o, load_pc_o, we_ir_o,
               load_addr_reg_o, mar_src_o, sel_alu_port_a_o, sel_alu_port_b_o,
               alu_op_o, re_mem_o, we_mem_o, halted_o, illegal_o, timeout_o, state_o
    );

    modport slave (
        output run_i, ir_i, mem_ready_i, alu_flag_i,
        input  en_rf_o, we_rf_o, sel_rf_o, en_pc_o, load_pc_o, we_ir_o,
               load_addr_reg_o, mar_src_o, sel_alu_port_a_o, sel_alu_port_b_o,
               alu_op_o, re_mem_o, we_mem_o, halted_o, illegal_o, timeout_o, state_o
    );
endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I-subset control FSM for core_dp: fetch/decode/execute/mem/writeback
// sequencing with a bounded wait on every memory access.
module core_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic        clk_i,
    input logic        rst_i,
    core_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
        ALU_XOR = 3'b100, ALU_SLL = 3'b101, ALU_SRL = 3'b110, ALU_SLT = 3'b111
    } alu_op_t;

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          halted_q, halted_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          is_r, is_i, is_ld, is_st, is_br, is_jal, is_sys;
    logic          illegal_dec;
    logic          br_taken;
    logic [TW-1:0] tcnt_inc;
    alu_op_t       alu_map;
    logic          unused_bits;

    assign opcode      = bus.ir_i[6:0];
    assign funct3      = bus.ir_i[14:12];
    assign is_r        = (opcode == 7'b0110011);
    assign is_i        = (opcode == 7'b0010011);
    assign is_ld       = (opcode == 7'b0000011);
    assign is_st       = (opcode == 7'b0100011);
    assign is_br       = (opcode == 7'b1100011);
    assign is_jal      = (opcode == 7'b1101111);
    assign is_sys      = (opcode == 7'b1110011);
    assign illegal_dec = !(is_r || is_i || is_ld || is_st || is_br || is_jal)
                       || ((is_r || is_i) && funct3 == 3'b011)
                       || (is_br && funct3[2:1] != 2'b00);
    // BEQ takes on zero, BNE on non-zero; funct3[0] distinguishes them.
    assign br_taken    = bus.alu_flag_i[0] ^ funct3[0];
    assign tcnt_inc    = tcnt_q + TW'(1);
    assign unused_bits = ^{bus.ir_i[31], bus.ir_i[29:15], bus.ir_i[11:7], bus.alu_flag_i[2:1]};

    always_comb begin
        alu_map = ALU_ADD;
        case (funct3)
            3'b000:  alu_map = (is_r && bus.ir_i[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_map = ALU_SLL;
            3'b010:  alu_map = ALU_SLT;
            3'b100:  alu_map = ALU_XOR;
            3'b101:  alu_map = ALU_SRL;
            3'b110:  alu_map = ALU_OR;
            3'b111:  alu_map = ALU_AND;
            default: alu_map = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = '0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        bus.en_rf_o          = 1'b0;
        bus.we_rf_o          = 1'b0;
        bus.sel_rf_o         = 1'b0;
        bus.en_pc_o          = 1'b0;
        bus.load_pc_o        = 1'b0;
        bus.we_ir_o          = 1'b0;
        bus.load_addr_reg_o  = 1'b0;
        bus.mar_src_o        = 1'b0;
        bus.sel_alu_port_a_o = 1'b0;
        bus.sel_alu_port_b_o = 1'b0;
        bus.alu_op_o         = ALU_ADD;
        bus.re_mem_o         = 1'b0;
        bus.we_mem_o         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run_i) begin
                    state_d = S_FETCH;
                    bus.load_addr_reg_o = 1'b1;
                end
            end
            S_FETCH: begin
                bus.re_mem_o = 1'b1;
                if (bus.mem_ready_i) begin
                    bus.we_ir_o = 1'b1;
                    state_d     = S_DECODE;
                end else if (tcnt_inc == TMAX) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            S_DECODE: begin
                if (is_sys) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (illegal_dec) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_r || is_i) begin
                    bus.sel_alu_port_b_o = is_i;
                    bus.alu_op_o         = alu_map;
                    state_d              = S_WB;
                end else if (is_ld || is_st) begin
                    bus.sel_alu_port_b_o = 1'b1;
                    bus.load_addr_reg_o  = 1'b1;
                    bus.mar_src_o        = 1'b1;
                    state_d              = S_MEM;
                end else if (is_br) begin
                    bus.alu_op_o = ALU_SUB;
                    if (br_taken) begin
                        state_d = S_BRANCH;
                    end else begin
                        bus.en_pc_o         = 1'b1;
                        bus.load_addr_reg_o = 1'b1;
                        state_d             = S_FETCH;
                    end
                end else begin
                    state_d = S_BRANCH;
                end
            end
            S_MEM: begin
                bus.re_mem_o = is_ld;
                bus.we_mem_o = !is_ld;
                if (bus.mem_ready_i) begin
                    if (is_ld) begin
                        state_d = S_WB;
                    end else begin
                        bus.en_pc_o         = 1'b1;
                        bus.load_addr_reg_o = 1'b1;
                        state_d             = S_FETCH;
                    end
                end else if (tcnt_inc == TMAX) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            S_WB: begin
                bus.en_rf_o         = 1'b1;
                bus.we_rf_o         = 1'b1;
                bus.en_pc_o         = 1'b1;
                bus.load_addr_reg_o = 1'b1;
                state_d             = S_FETCH;
                if (is_ld) begin
                    bus.sel_rf_o = 1'b1;
                end else begin
                    bus.sel_alu_port_b_o = is_i;
                    bus.alu_op_o         = alu_map;
                end
            end
            S_BRANCH: begin
                bus.sel_alu_port_a_o = 1'b1;
                bus.sel_alu_port_b_o = 1'b1;
                bus.load_pc_o        = 1'b1;
                bus.load_addr_reg_o  = 1'b1;
                state_d              = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.halted_o  = halted_q;
    assign bus.illegal_o = illegal_q;
    assign bus.timeout_o = timeout_q;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: per-cycle expected control vectors are queued as
// stimulus is driven and compared against the DUT on the following falling edge.
module tb_core_ctrl;
    logic clk_i = 1'b0;
    logic rst_i;
    core_ctrl_if bus ();

    core_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.master)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [20:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // {state, halted, illegal, timeout, en_rf, we_rf, sel_rf, en_pc, load_pc, we_ir,
    //  load_addr, mar_src, sel_a, sel_b, alu_op, re_mem, we_mem}
    logic [20:0] obs;
    assign obs = {bus.state_o, bus.halted_o, bus.illegal_o, bus.timeout_o,
                  bus.en_rf_o, bus.we_rf_o, bus.sel_rf_o, bus.en_pc_o, bus.load_pc_o,
                  bus.we_ir_o, bus.load_addr_reg_o, bus.mar_src_o,
                  bus.sel_alu_port_a_o, bus.sel_alu_port_b_o, bus.alu_op_o,
                  bus.re_mem_o, bus.we_mem_o};

    localparam logic [20:0] HALTED  = 21'd1 << 17;
    localparam logic [20:0] ILLEGAL = 21'd1 << 16;
    localparam logic [20:0] TMO     = 21'd1 << 15;
    localparam logic [20:0] EN_RF   = 21'd1 << 14;
    localparam logic [20:0] WE_RF   = 21'd1 << 13;
    localparam logic [20:0] SEL_RF  = 21'd1 << 12;
    localparam logic [20:0] EN_PC   = 21'd1 << 11;
    localparam logic [20:0] LD_PC   = 21'd1 << 10;
    localparam logic [20:0] WE_IR   = 21'd1 << 9;
    localparam logic [20:0] LA      = 21'd1 << 8;
    localparam logic [20:0] MAR_ALU = 21'd1 << 7;
    localparam logic [20:0] SEL_A   = 21'd1 << 6;
    localparam logic [20:0] SEL_B   = 21'd1 << 5;
    localparam logic [20:0] RE      = 21'd1 << 1;
    localparam logic [20:0] WE      = 21'd1;

    function automatic logic [20:0] st(input logic [2:0] s);
        return {s, 18'd0};
    endfunction

    function automatic logic [20:0] alu(input logic [2:0] op);
        return {16'd0, op, 2'b00};
    endfunction

    task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    end

    task automatic cyc(input string tag, input logic run, input logic [31:0] ir,
                       input logic rdy, input logic [2:0] flg, input logic [20:0] exp);
        rst_i           = 1'b0;
        bus.run_i       = run;
        bus.ir_i        = ir;
        bus.mem_ready_i = rdy;
        bus.alu_flag_i  = flg;
        sb.push_back('{tag, exp});
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input string tag, input logic [20:0] exp_during);
        rst_i           = 1'b1;
        bus.run_i       = 1'b0;
        bus.mem_ready_i = 1'b0;
        sb.push_back('{tag, exp_during});
        @(posedge clk_i);
        #1;
        cyc({tag, "_after"}, 1'b0, bus.ir_i, 1'b0, 3'b000, st(3'd0));
    endtask

    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] SUB   = 32'h40208033;
    localparam logic [31:0] SLTU  = 32'h0020B033;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] BNE   = 32'h00209463;
    localparam logic [31:0] JAL   = 32'h008000EF;
    localparam logic [31:0] LW    = 32'h0000A083;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] EBRK  = 32'h00100073;

    initial begin
        rst_i           = 1'b1;
        bus.run_i       = 1'b0;
        bus.ir_i        = '0;
        bus.mem_ready_i = 1'b0;
        bus.alu_flag_i  = '0;
        @(posedge clk_i);
        #1;
        cyc("reset_idle", 0, ADDI, 0, 3'b000, st(3'd0));

        // ADDI x1,x0,5 with immediate memory
        cyc("addi_idle",  1, ADDI, 1, 3'b000, st(3'd0) | LA);
        cyc("addi_fetch", 0, ADDI, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("addi_dec",   0, ADDI, 1, 3'b000, st(3'd2));
        cyc("addi_exec",  0, ADDI, 1, 3'b000, st(3'd3) | SEL_B | alu(3'b000));
        cyc("addi_wb",    0, ADDI, 1, 3'b000, st(3'd5) | SEL_B | EN_RF | WE_RF | EN_PC | LA);

        // SUB then SLTU (illegal)
        cyc("sub_fetch",  0, SUB, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("sub_dec",    0, SUB, 1, 3'b000, st(3'd2));
        cyc("sub_exec",   0, SUB, 1, 3'b000, st(3'd3) | alu(3'b001));
        cyc("sub_wb",     0, SUB, 1, 3'b000, st(3'd5) | alu(3'b001) | EN_RF | WE_RF | EN_PC | LA);
        cyc("sltu_fetch", 0, SLTU, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("sltu_dec",   0, SLTU, 1, 3'b000, st(3'd2));
        cyc("sltu_halt",  0, SLTU, 1, 3'b000, st(3'd7) | HALTED | ILLEGAL);
        cyc("halt_stay",  1, SLTU, 1, 3'b111, st(3'd7) | HALTED | ILLEGAL);
        do_reset("rst_halt", st(3'd7) | HALTED | ILLEGAL);

        // BEQ taken, BEQ not taken, BNE taken, JAL
        cyc("beq_idle",   1, BEQ, 1, 3'b001, st(3'd0) | LA);
        cyc("beq_fetch",  0, BEQ, 1, 3'b001, st(3'd1) | RE | WE_IR);
        cyc("beq_dec",    0, BEQ, 1, 3'b001, st(3'd2));
        cyc("beq_exec_t", 0, BEQ, 1, 3'b001, st(3'd3) | alu(3'b001));
        cyc("beq_branch", 0, BEQ, 1, 3'b001, st(3'd6) | SEL_A | SEL_B | LD_PC | LA);
        cyc("beqn_fetch", 0, BEQ, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("beqn_dec",   0, BEQ, 1, 3'b000, st(3'd2));
        cyc("beqn_exec",  0, BEQ, 1, 3'b000, st(3'd3) | alu(3'b001) | EN_PC | LA);
        cyc("bne_fetch",  0, BNE, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("bne_dec",    0, BNE, 1, 3'b000, st(3'd2));
        cyc("bne_exec_t", 0, BNE, 1, 3'b000, st(3'd3) | alu(3'b001));
        cyc("bne_branch", 0, BNE, 1, 3'b000, st(3'd6) | SEL_A | SEL_B | LD_PC | LA);
        cyc("jal_fetch",  0, JAL, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("jal_dec",    0, JAL, 1, 3'b000, st(3'd2));
        cyc("jal_exec",   0, JAL, 1, 3'b000, st(3'd3));
        cyc("jal_branch", 0, JAL, 1, 3'b000, st(3'd6) | SEL_A | SEL_B | LD_PC | LA);

        // LW with ready arriving on the last allowed MEM cycle, then SW
        cyc("lw_fetch",   0, LW, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("lw_dec",     0, LW, 1, 3'b000, st(3'd2));
        cyc("lw_exec",    0, LW, 1, 3'b000, st(3'd3) | SEL_B | LA | MAR_ALU);
        for (int i = 0; i < 3; i++)
            cyc("lw_mem_wait", 0, LW, 0, 3'b000, st(3'd4) | RE);
        cyc("lw_mem_rdy", 0, LW, 1, 3'b000, st(3'd4) | RE);
        cyc("lw_wb",      0, LW, 1, 3'b000, st(3'd5) | EN_RF | WE_RF | SEL_RF | EN_PC | LA);
        cyc("sw_fetch",   0, SW, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("sw_dec",     0, SW, 1, 3'b000, st(3'd2));
        cyc("sw_exec",    0, SW, 1, 3'b000, st(3'd3) | SEL_B | LA | MAR_ALU);
        cyc("sw_mem",     0, SW, 1, 3'b000, st(3'd4) | WE | EN_PC | LA);

        // fetch never acknowledged: timeout after MEM_TIMEOUT cycles
        for (int i = 0; i < 4; i++)
            cyc("to_fetch", 0, SW, 0, 3'b000, st(3'd1) | RE);
        cyc("to_halt",    0, SW, 1, 3'b000, st(3'd7) | HALTED | TMO);
        do_reset("rst_to", st(3'd7) | HALTED | TMO);

        // reset aborting a pending store, then EBREAK
        cyc("sw2_idle",   1, SW, 1, 3'b000, st(3'd0) | LA);
        cyc("sw2_fetch",  0, SW, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("sw2_dec",    0, SW, 1, 3'b000, st(3'd2));
        cyc("sw2_exec",   0, SW, 1, 3'b000, st(3'd3) | SEL_B | LA | MAR_ALU);
        cyc("sw2_mem",    0, SW, 0, 3'b000, st(3'd4) | WE);
        do_reset("rst_mem", st(3'd4) | WE);
        cyc("eb_idle",    1, EBRK, 1, 3'b000, st(3'd0) | LA);
        cyc("eb_fetch",   0, EBRK, 1, 3'b000, st(3'd1) | RE | WE_IR);
        cyc("eb_dec",     0, EBRK, 1, 3'b000, st(3'd2));
        cyc("eb_halt",    0, EBRK, 1, 3'b000, st(3'd7) | HALTED);

        check_eq("sb_drain", 21'(sb.size()), 21'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
